// File: rtl/fc_param_streamer.sv
// Streams a small per-class weight memory out as one VEC_LEN-beat packet with a
// ready/valid handshake. Optional macro FC_PARAM_STREAMER_AUTO_RESTART_EN chains packets back-to-back.

module fc_param_streamer_lane #(
  parameter int I_BW    = 8,
  parameter int BIAS_BW = 16,
  parameter int VEC_LEN = 8,
  parameter int ADDR_BW = $clog2(VEC_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we,
  input  logic [ADDR_BW-1:0] waddr,
  input  logic [I_BW-1:0]    wdata,
  input  logic [ADDR_BW-1:0] raddr,
  output logic [I_BW-1:0]    rdata,
  input  logic               bias_we,
  input  logic [BIAS_BW-1:0] bias_d,
  output logic [BIAS_BW-1:0] bias_q
);
  logic [I_BW-1:0] mem [VEC_LEN];

  // Weight rows survive reset on purpose, so there is no reset branch here.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-edge write bypass lets a row written together with start show on beat 0.
  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        bias_q <= '0;
    else if (bias_we) bias_q <= bias_d;
  end
endmodule

module fc_param_streamer #(
  parameter int I_BW        = 8,
  parameter int BIAS_BW     = I_BW*2,
  parameter int NUM_CLASSES = 3,
  parameter int VEC_LEN     = 8,
  parameter int ADDR_BW     = $clog2(VEC_LEN)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           wr_en_i,
  input  logic [ADDR_BW-1:0]             wr_addr_i,
  input  logic [NUM_CLASSES*I_BW-1:0]    wr_data_i,
  input  logic                           bias_wr_en_i,
  input  logic [NUM_CLASSES*BIAS_BW-1:0] bias_data_i,
  output logic [NUM_CLASSES*I_BW-1:0]    data_w_o,
  output logic [NUM_CLASSES*BIAS_BW-1:0] data_b_o,
  output logic                           valid_o,
  output logic                           last_o,
  input  logic                           ready_i,
  output logic                           busy_o,
  output logic                           done_o
);
  localparam logic [0:0]         IDLE     = 1'b0;
  localparam logic [0:0]         STREAM   = 1'b1;
  localparam logic [ADDR_BW-1:0] LAST_IDX = ADDR_BW'(VEC_LEN-1);
  localparam logic [ADDR_BW-1:0] ONE      = ADDR_BW'(1);

  logic [0:0]                    state_q;
  logic [ADDR_BW-1:0]            cnt_q, rd_idx;
  logic [NUM_CLASSES*I_BW-1:0]   rd_row, data_w_q;
  logic                          valid_q, done_q;
  logic                          addr_ok, mem_we, bias_we, xfer, at_last;

  assign addr_ok = 32'(wr_addr_i) < VEC_LEN;
  assign mem_we  = (state_q == IDLE) && wr_en_i && addr_ok;
  assign bias_we = (state_q == IDLE) && bias_wr_en_i;
  assign xfer    = valid_q && ready_i;
  assign at_last = (cnt_q == LAST_IDX);
  // Prefetch address: row 0 when starting or wrapping, else the row after the current beat.
  assign rd_idx  = ((state_q == IDLE) || at_last) ? '0 : cnt_q + ONE;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
    fc_param_streamer_lane #(
      .I_BW(I_BW), .BIAS_BW(BIAS_BW), .VEC_LEN(VEC_LEN), .ADDR_BW(ADDR_BW)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we      (mem_we),
      .waddr   (wr_addr_i),
      .wdata   (wr_data_i[c*I_BW +: I_BW]),
      .raddr   (rd_idx),
      .rdata   (rd_row[c*I_BW +: I_BW]),
      .bias_we (bias_we),
      .bias_d  (bias_data_i[c*BIAS_BW +: BIAS_BW]),
      .bias_q  (data_b_o[c*BIAS_BW +: BIAS_BW])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      data_w_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= STREAM;
            valid_q  <= 1'b1;
            cnt_q    <= '0;
            data_w_q <= rd_row;
          end
        end
        default: begin
          if (xfer) begin
            if (at_last) begin
              done_q <= 1'b1;
              cnt_q  <= '0;
`ifdef FC_PARAM_STREAMER_AUTO_RESTART_EN
              data_w_q <= rd_row;
`else
              state_q <= IDLE;
              valid_q <= 1'b0;
`endif
            end else begin
              cnt_q    <= cnt_q + ONE;
              data_w_q <= rd_row;
            end
          end
        end
      endcase
    end
  end

  assign data_w_o = data_w_q;
  assign valid_o  = valid_q;
  assign last_o   = valid_q && at_last;
  assign busy_o   = (state_q == STREAM);
  assign done_o   = done_q;
endmodule

// File: tb/tb_fc_param_streamer.sv
// Directed bench for fc_param_streamer at VEC_LEN=4, NUM_CLASSES=3.
// Define FC_PARAM_STREAMER_AUTO_RESTART_EN to exercise the back-to-back build.

module tb_fc_param_streamer;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, wr_en_i, bias_wr_en_i, ready_i;
  logic [1:0]  wr_addr_i;
  logic [23:0] wr_data_i, data_w_o;
  logic [47:0] bias_data_i, data_b_o;
  logic        valid_o, last_o, busy_o, done_o;

  int chk = 0;
  int err = 0;

  logic [23:0] rows [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
  localparam logic [47:0] BIAS = 48'h0001_0002_0003;

  fc_param_streamer #(.I_BW(8), .NUM_CLASSES(3), .VEC_LEN(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .bias_wr_en_i(bias_wr_en_i),
    .bias_data_i(bias_data_i), .data_w_o(data_w_o), .data_b_o(data_b_o),
    .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic load_all();
    for (int i = 0; i < 4; i++) begin
      wr_en_i = 1'b1; wr_addr_i = 2'(i); wr_data_i = rows[i];
      tick();
    end
    wr_en_i = 1'b0;
    bias_wr_en_i = 1'b1; bias_data_i = BIAS;
    tick();
    bias_wr_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 0; wr_en_i = 0; bias_wr_en_i = 0; ready_i = 0;
    wr_addr_i = '0; wr_data_i = '0; bias_data_i = '0;
    tick(); tick();
    chk++;
    if (valid_o !== 0 || last_o !== 0 || busy_o !== 0 || done_o !== 0 ||
        data_w_o !== 24'h0 || data_b_o !== 48'h0) begin
      err++;
      $display("FAIL reset_state: v=%b l=%b b=%b d=%b w=%h bias=%h, want all zero",
               valid_o, last_o, busy_o, done_o, data_w_o, data_b_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    start_i = 1; ready_i = 1; tick(); start_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk++;
      if (valid_o !== 1 || busy_o !== 1 || data_w_o !== rows[i] || last_o !== (i == 3)) begin
        err++;
        $display("FAIL basic_beat%0d: v=%b busy=%b w=%h l=%b, want v=1 busy=1 w=%h l=%b",
                 i, valid_o, busy_o, data_w_o, last_o, rows[i], (i == 3));
      end
      chk++;
      if (data_b_o !== BIAS) begin
        err++; $display("FAIL basic_bias%0d: got %h want %h", i, data_b_o, BIAS);
      end
      tick();
    end
    chk++;
    if (valid_o !== 0 || done_o !== 1 || busy_o !== 0) begin
      err++; $display("FAIL basic_done: v=%b d=%b busy=%b, want 0 1 0", valid_o, done_o, busy_o);
    end
    tick();
    chk++;
    if (done_o !== 0 || valid_o !== 0) begin
      err++; $display("FAIL basic_done_pulse: d=%b v=%b, want 0 0", done_o, valid_o);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int cycles = 0;
    start_i = 1; ready_i = 1; tick(); start_i = 0;
    for (int cyc = 0; cyc < 12 && k < 4; cyc++) begin
      ready_i = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
      chk++;
      if (valid_o !== 1 || data_w_o !== rows[k] || last_o !== (k == 3)) begin
        err++;
        $display("FAIL stall_cyc%0d: v=%b w=%h l=%b, want v=1 w=%h l=%b",
                 cyc, valid_o, data_w_o, last_o, rows[k], (k == 3));
      end
      tick();
      cycles++;
      if (ready_i) k++;
    end
    chk++;
    if (k != 4 || cycles != 6 || valid_o !== 0 || done_o !== 1) begin
      err++;
      $display("FAIL stall_total: beats=%0d cycles=%0d v=%b d=%b, want 4 6 0 1",
               k, cycles, valid_o, done_o);
    end
    ready_i = 1; tick();
  endtask

  task automatic test_stream_ignore();
    start_i = 1; ready_i = 0; tick(); start_i = 0;
    wr_en_i = 1; wr_addr_i = 2'd1; wr_data_i = 24'hFFFFFF; start_i = 1;
    bias_wr_en_i = 1; bias_data_i = 48'hFFFF_FFFF_FFFF;
    tick();
    wr_en_i = 0; start_i = 0; bias_wr_en_i = 0;
    chk++;
    if (valid_o !== 1 || data_w_o !== rows[0] || last_o !== 0 || data_b_o !== BIAS) begin
      err++;
      $display("FAIL ignore_hold: v=%b w=%h l=%b bias=%h, want 1 %h 0 %h",
               valid_o, data_w_o, last_o, data_b_o, rows[0], BIAS);
    end
    for (int pkt = 0; pkt < 2; pkt++) begin
      if (pkt == 1) begin
        start_i = 1; tick(); start_i = 0;
      end
      ready_i = 1;
      for (int i = 0; i < 4; i++) begin
        chk++;
        if (valid_o !== 1 || data_w_o !== rows[i]) begin
          err++;
          $display("FAIL ignore_pkt%0d_beat%0d: v=%b w=%h, want 1 %h",
                   pkt, i, valid_o, data_w_o, rows[i]);
        end
        tick();
      end
      chk++;
      if (done_o !== 1 || busy_o !== 0) begin
        err++; $display("FAIL ignore_pkt%0d_done: d=%b busy=%b, want 1 0", pkt, done_o, busy_o);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_i = 1; ready_i = 1; tick(); start_i = 0;
    tick();
    chk++;
    if (valid_o !== 1 || data_w_o !== rows[1]) begin
      err++; $display("FAIL rstmid_beat1: v=%b w=%h, want 1 %h", valid_o, data_w_o, rows[1]);
    end
    rst_i = 1; #1;
    chk++;
    if (valid_o !== 0 || busy_o !== 0 || last_o !== 0 || done_o !== 0 ||
        data_w_o !== 24'h0 || data_b_o !== 48'h0) begin
      err++;
      $display("FAIL rstmid_async: v=%b busy=%b l=%b d=%b w=%h bias=%h, want all zero",
               valid_o, busy_o, last_o, done_o, data_w_o, data_b_o);
    end
    #1 rst_i = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk++;
      if (valid_o !== 0 || busy_o !== 0) begin
        err++; $display("FAIL rstmid_quiet%0d: v=%b busy=%b, want 0 0", c, valid_o, busy_o);
      end
    end
    start_i = 1; tick(); start_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk++;
      if (valid_o !== 1 || data_w_o !== rows[i] || data_b_o !== 48'h0) begin
        err++;
        $display("FAIL rstmid_beat%0d: v=%b w=%h bias=%h, want 1 %h 0",
                 i, valid_o, data_w_o, data_b_o, rows[i]);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_same_edge_write();
    wr_en_i = 1; wr_addr_i = 2'd0; wr_data_i = 24'h111111; start_i = 1; ready_i = 1;
    tick();
    wr_en_i = 0; start_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk++;
      if (valid_o !== 1 || data_w_o !== ((i == 0) ? 24'h111111 : rows[i])) begin
        err++;
        $display("FAIL sameedge_beat%0d: v=%b w=%h, want 1 %h",
                 i, valid_o, data_w_o, (i == 0) ? 24'h111111 : rows[i]);
      end
      tick();
    end
    chk++;
    if (done_o !== 1 || valid_o !== 0) begin
      err++; $display("FAIL sameedge_done: d=%b v=%b, want 1 0", done_o, valid_o);
    end
  endtask

  task automatic test_auto_restart();
    start_i = 1; ready_i = 1; tick(); start_i = 0;
    for (int i = 0; i < 8; i++) begin
      chk++;
      if (valid_o !== 1 || busy_o !== 1 || data_w_o !== rows[i % 4] ||
          last_o !== ((i % 4) == 3) || done_o !== (i == 4)) begin
        err++;
        $display("FAIL auto_beat%0d: v=%b busy=%b w=%h l=%b d=%b, want 1 1 %h %b %b",
                 i, valid_o, busy_o, data_w_o, last_o, done_o, rows[i % 4],
                 ((i % 4) == 3), (i == 4));
      end
      tick();
    end
    chk++;
    if (done_o !== 1 || valid_o !== 1 || data_w_o !== rows[0]) begin
      err++;
      $display("FAIL auto_wrap: d=%b v=%b w=%h, want 1 1 %h", done_o, valid_o, data_w_o, rows[0]);
    end
    rst_i = 1; tick(); rst_i = 0;
  endtask

  initial begin
    test_reset();
    load_all();
`ifdef FC_PARAM_STREAMER_AUTO_RESTART_EN
    test_auto_restart();
`else
    test_basic();
    test_stall();
    test_stream_ignore();
    test_reset_mid();
    test_same_edge_write();
`endif
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule

// File: doc/fc_param_streamer.md
FC_PARAM_STREAMER -- requirements
Module: fc_param_streamer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- I_BW, 8, weight bitwidth per class
- BIAS_BW, I_BW*2, bias bitwidth per class
- NUM_CLASSES, 3, output classes
- VEC_LEN, 8, beats per packet, at least 4
- ADDR_BW, $clog2(VEC_LEN), write-address width
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  the single clock; all logic on its rising edge
- rst_i  in  1  reset, asynchronous and active-high
- start_i  in  1  begin one packet
- wr_en_i  in  1  weight-memory write strobe
- wr_addr_i  in  ADDR_BW  weight-memory write address
- wr_data_i  in  NUM_CLASSES*I_BW  packed weight row, class i at bits [(i+1)*I_BW-1 : i*I_BW]
- bias_wr_en_i  in  1  bias-register write strobe
- bias_data_i  in  NUM_CLASSES*BIAS_BW  packed biases
- data_w_o  out  NUM_CLASSES*I_BW  current weight row
- data_b_o  out  NUM_CLASSES*BIAS_BW  bias register contents
- valid_o  out  1  beat valid
- last_o  out  1  final beat of packet
- ready_i  in  1  downstream accepts the beat
- busy_o  out  1  packet in progress
- done_o  out  1  one-cycle pulse after the final beat is accepted

Function
REQ-003 Weight memory SHALL be VEC_LEN flop rows of NUM_CLASSES*I_BW bits with combinational read into registered outputs.
REQ-004 The FSM SHALL have two states, IDLE and STREAM; busy_o SHALL be 1 exactly in STREAM.
REQ-005 IDLE with start_i=1 at edge t SHALL give STREAM at t+1 with valid_o=1, data_w_o=mem[0], beat counter=0.
REQ-006 A beat SHALL transfer on an edge where valid_o and ready_i are both 1; on transfer the counter SHALL increment and data_w_o SHALL load mem[counter+1] with no bubble cycle.
REQ-007 With ready_i=0, data_w_o, last_o and valid_o SHALL hold.
REQ-008 last_o SHALL equal valid_o AND (counter == VEC_LEN-1).
REQ-009 On transfer of the last beat, the block SHALL return to IDLE with valid_o=0 and pulse done_o for exactly one cycle.
REQ-010 data_b_o SHALL drive the bias register continuously, not only on last_o.
REQ-011 start_i in STREAM SHALL be ignored.
REQ-012 wr_en_i and bias_wr_en_i SHALL take effect only in IDLE and SHALL be ignored in STREAM.
REQ-013 Writing the current weight row and start_i on the same edge SHALL make the new data visible on beat 0.
REQ-014 wr_addr_i >= VEC_LEN SHALL be ignored.

Reset
REQ-015 rst_i=1 SHALL immediately force IDLE, counter=0, valid_o=0, last_o=0, busy_o=0, done_o=0, data_w_o=0 and bias register=0, including in the middle of a packet.
REQ-016 Reset SHALL NOT clear weight-memory rows.
REQ-017 After rst_i deasserts, no beat SHALL be emitted until start_i.

Configuration
REQ-018 Macro FC_PARAM_STREAMER_AUTO_RESTART_EN:
- When defined: a last-beat transfer SHALL stay in STREAM, reload mem[0] with counter=0 and pulse done_o, so packets are back-to-back with no idle cycle.
- When not defined: REQ-009 applies.

Verification
REQ-019 The bench SHALL cover these directed scenarios with VEC_LEN=4, NUM_CLASSES=3:
- Rows 0..3 written as 0x010203, 0x040506, 0x070809, 0x0A0B0C, bias 0x0001_0002_0003, start_i with ready_i=1 -> four consecutive beats in that row order; last_o on beat 3 only; done_o pulse one cycle later; data_b_o=0x000100020003 throughout.
- ready_i=0 during cycles 2-3 of a packet -> beat 1 held stable, no row skipped or duplicated, four transfers total.
- Write to row 1 (0xFFFFFF) during STREAM, plus start_i -> write and start ignored; the next packet still emits 0x040506 on beat 1.
- rst_i pulsed after beat 1 -> valid_o=0 in the same cycle; a new start emits from row 0 with rows preserved, bias=0.
- Write to row 0 (0x111111) on the same edge as start_i -> beat 0 = 0x111111.
- AUTO_RESTART_EN defined, ready_i=1 -> eight beats in 8 cycles, last_o on beats 3 and 7.
